alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- Decode→execute pipeline register that feeds the ALU's reg1, reg2 and ALUsel inputs.
- Captures decoded operands under a valid/ready handshake.
- Resolves RAW hazards by forwarding from the EX/MEM result and the MEM/WB write-back buses.
- Selects the immediate for reg2 when required, and holds its contents stable while the ALU's consumer stalls.

Parameters:
- XLEN, 32, datapath width of operands and forwarded results.
- REG_AW, 5, register-address width (x0..x31).

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous reset, active-low
- flush  in  1  synchronous kill of held and incoming entry (branch/jump redirect)
- in_valid  in  1  decode presents an entry
- in_ready  out  1  stage can accept this cycle
- in_rs1, in_rs2  in  REG_AW  source register addresses
- in_rs1_data, in_rs2_data  in  XLEN  register-file read data
- in_imm  in  XLEN  sign/shift-extended immediate
- in_use_imm  in  1  1: reg2 takes in_imm, rs2 not forwarded
- in_alu_sel  in  4  ALU operation code
- in_rd  in  REG_AW  destination register
- in_reg_write  in  1  entry writes rd
- exm_we  in  1  EX/MEM stage will write exm_rd
- exm_rd  in  REG_AW  EX/MEM destination
- exm_result  in  XLEN  EX/MEM ALU result
- wb_we  in  1  write-back valid
- wb_rd  in  REG_AW  write-back destination
- wb_data  in  XLEN  write-back data
- out_valid  out  1  reg1/reg2/alu_sel valid for ALU
- out_ready  in  1  downstream consumes entry this cycle
- reg1, reg2  out  XLEN  ALU operands
- alu_sel  out  4  ALU operation
- out_rd  out  REG_AW  registered in_rd
- out_reg_write  out  1  registered in_reg_write, forced 0 when out_valid=0

Behaviour:
- Reset (rst_n=0, async): out_valid=0, reg1=0, reg2=0, alu_sel=4'b0000, out_rd=0, out_reg_write=0, internal held rs1/rs2=0.
- in_ready = ~out_valid | out_ready (combinational). It does not depend on flush.
- Capture occurs when in_valid & in_ready & ~flush. Latency is 1 cycle: the entry appears on outputs with out_valid=1 on the next edge.
- Drain without capture: out_ready=1 and no capture → out_valid←0.
- Hold: out_valid=1 and out_ready=0 → all outputs keep their values, except for snoop updates (see Optional Feature).
- Flush: out_valid←0 and out_reg_write←0 next edge. A simultaneous in_valid entry is dropped. Flush wins over every other event.
- Forwarding at capture, per source s ∈ {rs1, rs2}:
  - If s==0, operand = register-file data (x0 is never forwarded).
  - Else if exm_we & exm_rd==s, operand = exm_result. EX/MEM has highest priority.
  - Else if wb_we & wb_rd==s, operand = wb_data.
  - Else operand = register-file data.
- reg2 = in_imm when in_use_imm=1, regardless of forwarding hits.
- alu_sel, out_rd, out_reg_write are copied unmodified. No arithmetic is performed here; all widths are XLEN with no extension.
- Back-to-back: capture and drain in the same cycle yields a new entry every cycle. Throughput is 1/cycle.
- Reset asserted mid-hold clears immediately and asynchronously; no partial entry survives.

Optional Feature:
- Macro: ALU_OPSTAGE_SNOOP_EN
- Defined: while out_valid=1 and out_ready=0 (held), each edge with wb_we=1, wb_rd≠0 and wb_rd matching the held rs1 updates reg1←wb_data.
  - Same rule for rs2/reg2 when the held entry did not use the immediate.
  - Requires storing held rs1, rs2 and use_imm.
- Undefined: held operands are frozen. Upstream interlock guarantees no write-back to a held source during a stall, and the rs/use_imm storage is omitted.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN and REG_AW defaults.
  - ALU op constants: ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_LUI=4'b0011, ALU_SUB=4'b0110, ALU_SLT=4'b0111, ALU_NOR=4'b1100.
- One sub-module, fwd_mux: combinational 3-source priority select with x0 guard, instantiated once per source operand.

Test Plan:
- Reset: rst_n=0 mid-stream with out_valid=1 → all outputs 0 immediately; after release, in_ready=1.
- EX/MEM vs WB priority: in_rs1=5, in_rs1_data=0x11, exm_we=1/exm_rd=5/exm_result=0xAA, wb_we=1/wb_rd=5/wb_data=0xBB → next cycle reg1=0xAA.
- x0 guard and immediate: in_rs1=0, exm_rd=0, exm_we=1, in_rs1_data=0, in_use_imm=1, in_imm=0x12345000, in_alu_sel=ALU_LUI → reg1=0, reg2=0x12345000, alu_sel=4'b0011.
- Stall then drain: capture A, out_ready=0 for 3 cycles while in_valid=1 with B → in_ready=0 and outputs stay A. Then out_ready=1 → B appears the following cycle, with no loss or duplication.
- Flush during capture: out_valid=1, in_valid=1, flush=1 → next cycle out_valid=0, out_reg_write=0, and the incoming entry is never presented.
- Snoop (ALU_OPSTAGE_SNOOP_EN defined): held entry rs2=7 with in_use_imm=0 and reg2=0x1; wb_we=1/wb_rd=7/wb_data=0x99 during the stall → reg2=0x99 next edge. With the macro undefined, reg2 stays 0x1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: default datapath/register-address widths and ALU op codes.
package riscv_pkg;

  localparam int DEF_XLEN   = 32;
  localparam int DEF_REG_AW = 5;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage : riscv_pkg

// File: rtl/alu_operand_stage_fwd_mux.sv
// Operand forwarding select: EX/MEM result over write-back data over register file, x0 never forwarded.
module fwd_mux
  import riscv_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [XLEN-1:0]   rf_data,
  input  logic              exm_we,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [XLEN-1:0]   exm_result,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   data
);

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves data unassigned (no latch).
    data = rf_data;
    if (rs != '0) begin
      if (exm_we && (exm_rd == rs)) begin
        data = exm_result;
      end else if (wb_we && (wb_rd == rs)) begin
        data = wb_data;
      end
    end
  end

endmodule : fwd_mux

// File: rtl/alu_operand_stage.sv
// Decode->execute operand register feeding the ALU, with RAW forwarding and immediate select.
// Optional write-back snooping of held operands is enabled by defining ALU_OPSTAGE_SNOOP_EN.
module alu_operand_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic              in_use_imm,
  input  logic [3:0]        in_alu_sel,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_reg_write,
  input  logic              exm_we,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [XLEN-1:0]   exm_result,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   reg1,
  output logic [XLEN-1:0]   reg2,
  output logic [3:0]        alu_sel,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write
);

  logic            capture;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic [XLEN-1:0] op2_next;

  // Ready is independent of flush so upstream handshake timing never depends on redirects.
  assign in_ready = ~out_valid | out_ready;
  assign capture  = in_valid & in_ready & ~flush;

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
    .rs         (in_rs1),
    .rf_data    (in_rs1_data),
    .exm_we     (exm_we),
    .exm_rd     (exm_rd),
    .exm_result (exm_result),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .data       (rs1_fwd)
  );

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
    .rs         (in_rs2),
    .rf_data    (in_rs2_data),
    .exm_we     (exm_we),
    .exm_rd     (exm_rd),
    .exm_result (exm_result),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .data       (rs2_fwd)
  );

  assign op2_next = in_use_imm ? in_imm : rs2_fwd;

`ifdef ALU_OPSTAGE_SNOOP_EN
  logic [REG_AW-1:0] held_rs1;
  logic [REG_AW-1:0] held_rs2;
  logic              held_use_imm;
  logic              hold;
  logic              wb_live;
  logic              snoop_rs1;
  logic              snoop_rs2;

  assign hold      = out_valid & ~out_ready & ~flush;
  assign wb_live   = wb_we & (wb_rd != '0);
  assign snoop_rs1 = hold & wb_live & (wb_rd == held_rs1);
  assign snoop_rs2 = hold & wb_live & (wb_rd == held_rs2) & ~held_use_imm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_rs1     <= '0;
      held_rs2     <= '0;
      held_use_imm <= 1'b0;
    end else if (capture) begin
      held_rs1     <= in_rs1;
      held_rs2     <= in_rs2;
      held_use_imm <= in_use_imm;
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      reg1          <= '0;
      reg2          <= '0;
      alu_sel       <= ALU_AND;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
    end else if (flush) begin
      out_valid     <= 1'b0;
      out_reg_write <= 1'b0;
    end else if (capture) begin
      out_valid     <= 1'b1;
      reg1          <= rs1_fwd;
      reg2          <= op2_next;
      alu_sel       <= in_alu_sel;
      out_rd        <= in_rd;
      out_reg_write <= in_reg_write;
    end else if (out_ready) begin
      out_valid     <= 1'b0;
      out_reg_write <= 1'b0;
    end
`ifdef ALU_OPSTAGE_SNOOP_EN
    else begin
      if (snoop_rs1) reg1 <= wb_data;
      if (snoop_rs2) reg2 <= wb_data;
    end
`endif
  end

endmodule : alu_operand_stage

// File: tb/tb_alu_operand_stage.sv
// Directed self-checking bench for alu_operand_stage: reset, forwarding, immediate, stall, flush, snoop.
module tb_alu_operand_stage;
  import riscv_pkg::*;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [REG_AW-1:0] in_rs1, in_rs2;
  logic [XLEN-1:0]   in_rs1_data, in_rs2_data;
  logic [XLEN-1:0]   in_imm;
  logic              in_use_imm;
  logic [3:0]        in_alu_sel;
  logic [REG_AW-1:0] in_rd;
  logic              in_reg_write;
  logic              exm_we;
  logic [REG_AW-1:0] exm_rd;
  logic [XLEN-1:0]   exm_result;
  logic              wb_we;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   reg1, reg2;
  logic [3:0]        alu_sel;
  logic [REG_AW-1:0] out_rd;
  logic              out_reg_write;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_operand_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rs1        (in_rs1),
    .in_rs2        (in_rs2),
    .in_rs1_data   (in_rs1_data),
    .in_rs2_data   (in_rs2_data),
    .in_imm        (in_imm),
    .in_use_imm    (in_use_imm),
    .in_alu_sel    (in_alu_sel),
    .in_rd         (in_rd),
    .in_reg_write  (in_reg_write),
    .exm_we        (exm_we),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .wb_we         (wb_we),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .reg1          (reg1),
    .reg2          (reg2),
    .alu_sel       (alu_sel),
    .out_rd        (out_rd),
    .out_reg_write (out_reg_write)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush        = 1'b0;
    in_valid     = 1'b0;
    in_rs1       = '0;
    in_rs2       = '0;
    in_rs1_data  = '0;
    in_rs2_data  = '0;
    in_imm       = '0;
    in_use_imm   = 1'b0;
    in_alu_sel   = ALU_AND;
    in_rd        = '0;
    in_reg_write = 1'b0;
    exm_we       = 1'b0;
    exm_rd       = '0;
    exm_result   = '0;
    wb_we        = 1'b0;
    wb_rd        = '0;
    wb_data      = '0;
    out_ready    = 1'b1;
  endtask

  task automatic drive_entry(input logic [4:0] rs1, input logic [31:0] rs1_data,
                             input logic [4:0] rs2, input logic [31:0] rs2_data,
                             input logic [3:0] sel, input logic [4:0] rd, input logic rw);
    in_valid     = 1'b1;
    in_rs1       = rs1;
    in_rs1_data  = rs1_data;
    in_rs2       = rs2;
    in_rs2_data  = rs2_data;
    in_alu_sel   = sel;
    in_rd        = rd;
    in_reg_write = rw;
    in_use_imm   = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_reg1"}, reg1, 32'd0);
    check({tag, "_reg2"}, reg2, 32'd0);
    check({tag, "_alu_sel"}, {28'd0, alu_sel}, 32'd0);
    check({tag, "_out_rd"}, {27'd0, out_rd}, 32'd0);
    check({tag, "_out_reg_write"}, {31'd0, out_reg_write}, 32'd0);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #2;
    check_cleared("reset");
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    rst_n = 1'b1;

    // EX/MEM wins over WB for the same source register.
    drive_entry(5'd5, 32'h11, 5'd6, 32'h22, ALU_ADD, 5'd3, 1'b1);
    exm_we = 1'b1; exm_rd = 5'd5; exm_result = 32'hAA;
    wb_we  = 1'b1; wb_rd  = 5'd5; wb_data    = 32'hBB;
    tick();
    check("prio_valid", {31'd0, out_valid}, 32'd1);
    check("prio_reg1", reg1, 32'hAA);
    check("prio_reg2", reg2, 32'h22);
    check("prio_alu_sel", {28'd0, alu_sel}, 32'h2);
    check("prio_out_rd", {27'd0, out_rd}, 32'd3);
    check("prio_out_reg_write", {31'd0, out_reg_write}, 32'd1);

    // WB forward on rs2; EX/MEM match on rs1 ignored because exm_we=0.
    drive_entry(5'd8, 32'h33, 5'd9, 32'h44, ALU_SUB, 5'd4, 1'b0);
    exm_we = 1'b0; exm_rd = 5'd8; exm_result = 32'hCC;
    wb_we  = 1'b1; wb_rd  = 5'd9; wb_data    = 32'hDD;
    tick();
    check("wbfwd_reg1", reg1, 32'h33);
    check("wbfwd_reg2", reg2, 32'hDD);
    check("wbfwd_alu_sel", {28'd0, alu_sel}, 32'h6);
    check("wbfwd_out_rd", {27'd0, out_rd}, 32'd4);
    check("wbfwd_out_reg_write", {31'd0, out_reg_write}, 32'd0);

    // x0 is never forwarded; immediate drives reg2.
    drive_entry(5'd0, 32'h0, 5'd0, 32'h0, ALU_LUI, 5'd7, 1'b1);
    in_use_imm = 1'b1; in_imm = 32'h12345000;
    exm_we = 1'b1; exm_rd = 5'd0; exm_result = 32'hFF;
    wb_we  = 1'b1; wb_rd  = 5'd0; wb_data    = 32'hFE;
    tick();
    check("x0_reg1", reg1, 32'h0);
    check("x0_reg2_imm", reg2, 32'h12345000);
    check("x0_alu_sel", {28'd0, alu_sel}, 32'h3);

    // Immediate overrides an EX/MEM hit on rs2.
    drive_entry(5'd1, 32'h1, 5'd5, 32'h55, ALU_OR, 5'd2, 1'b1);
    in_use_imm = 1'b1; in_imm = 32'h7FF;
    exm_we = 1'b1; exm_rd = 5'd5; exm_result = 32'hAB;
    wb_we  = 1'b0;
    tick();
    check("imm_over_fwd_reg1", reg1, 32'h1);
    check("imm_over_fwd_reg2", reg2, 32'h7FF);

    // Stall: A held for three cycles while B waits, then B follows exactly once.
    idle_inputs();
    drive_entry(5'd2, 32'hA1, 5'd3, 32'hA2, ALU_AND, 5'd1, 1'b1);
    tick();
    drive_entry(5'd4, 32'hB1, 5'd7, 32'hB2, ALU_NOR, 5'd2, 1'b1);
    out_ready = 1'b0;
    #1;
    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_reg1", reg1, 32'hA1);
      check("stall_reg2", reg2, 32'hA2);
      check("stall_out_rd", {27'd0, out_rd}, 32'd1);
      check("stall_in_ready_hold", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("drain_b_valid", {31'd0, out_valid}, 32'd1);
    check("drain_b_reg1", reg1, 32'hB1);
    check("drain_b_reg2", reg2, 32'hB2);
    check("drain_b_alu_sel", {28'd0, alu_sel}, 32'hC);
    check("drain_b_out_rd", {27'd0, out_rd}, 32'd2);
    in_valid = 1'b0;
    tick();
    check("drain_empty_valid", {31'd0, out_valid}, 32'd0);
    check("drain_empty_reg_write", {31'd0, out_reg_write}, 32'd0);

    // Flush drops both the held entry and the incoming one.
    drive_entry(5'd1, 32'hC1, 5'd2, 32'hC2, ALU_ADD, 5'd5, 1'b1);
    tick();
    check("flush_pre_valid", {31'd0, out_valid}, 32'd1);
    drive_entry(5'd3, 32'hD1, 5'd4, 32'hD2, ALU_SLT, 5'd6, 1'b1);
    flush = 1'b1;
    #1;
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_reg_write", {31'd0, out_reg_write}, 32'd0);
    flush = 1'b0;
    in_valid = 1'b0;
    tick();
    check("flush_dropped_valid", {31'd0, out_valid}, 32'd0);

    // Held entry sees a write-back to its rs2 during a stall.
    drive_entry(5'd6, 32'h5, 5'd7, 32'h1, ALU_ADD, 5'd8, 1'b1);
    tick();
    check("snoop_pre_reg2", reg2, 32'h1);
    in_valid = 1'b0;
    out_ready = 1'b0;
    wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h99;
    tick();
    wb_we = 1'b0;
`ifdef ALU_OPSTAGE_SNOOP_EN
    check("snoop_reg2", reg2, 32'h99);
`else
    check("snoop_reg2_frozen", reg2, 32'h1);
`endif
    check("snoop_reg1", reg1, 32'h5);
    check("snoop_valid", {31'd0, out_valid}, 32'd1);

    // Asynchronous reset while holding a valid entry.
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("midhold_reset");
    tick();
    rst_n = 1'b1;
    #1;
    check("midhold_in_ready", {31'd0, in_ready}, 32'd1);
    check("midhold_valid_after", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_alu_operand_stage
